// File: rtl/pic_cw_pkg.sv
// Shared codes, state constants and helpers for the PIC command-word sequencer.
package pic_cw_pkg;

    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned RSEL_W  = 3;

    // Command codes presented on cw_flag
    localparam logic [FLAG_W-1:0] FLAG_ICW1 = 3'd0;
    localparam logic [FLAG_W-1:0] FLAG_ICW2 = 3'd1;
    localparam logic [FLAG_W-1:0] FLAG_ICW3 = 3'd2;
    localparam logic [FLAG_W-1:0] FLAG_ICW4 = 3'd3;
    localparam logic [FLAG_W-1:0] FLAG_OCW1 = 3'd4;
    localparam logic [FLAG_W-1:0] FLAG_OCW2 = 3'd5;
    localparam logic [FLAG_W-1:0] FLAG_OCW3 = 3'd6;
    localparam logic [FLAG_W-1:0] FLAG_IDLE = 3'b111;

    // Register selects for CPU status reads
    localparam logic [RSEL_W-1:0] RSEL_IMR  = 3'b011;
    localparam logic [RSEL_W-1:0] RSEL_IRR  = 3'b001;
    localparam logic [RSEL_W-1:0] RSEL_ISR  = 3'b101;
    localparam logic [RSEL_W-1:0] RSEL_NONE = 3'b000;

    // Initialisation / operating states
    localparam logic [STATE_W-1:0] UNINIT    = 3'd0;
    localparam logic [STATE_W-1:0] WAIT_ICW2 = 3'd1;
    localparam logic [STATE_W-1:0] WAIT_ICW3 = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_ICW4 = 3'd3;
    localparam logic [STATE_W-1:0] READY     = 3'd4;

    // Command word as handed to the control logic
    typedef struct packed {
        logic [FLAG_W-1:0] flag;
        logic [DATA_W-1:0] data;
    } cw_word_t;

    // ICW1 is recognised in every state: A0=0 with D4 set
    function automatic logic is_icw1(input logic a0, input logic [DATA_W-1:0] d);
        return (!a0) && d[4];
    endfunction

endpackage

// File: rtl/wr_edge_sync.sv
// WR_n synchroniser with rising-edge detection producing a one-cycle write event.
module wr_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_n,
    output logic wr_evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift chain and edge history; cleared to 1 so reset release never looks like a rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wr_n};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign wr_evt = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/icw_ocw_sequencer.sv
// Write sequencer: tracks the ICW1..ICW4 init order, then decodes OCW1/2/3.
module icw_ocw_sequencer
    import pic_cw_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS_n,
    input  logic              WR_n,
    input  logic              RD_n,
    input  logic              A0,
    input  logic [DATA_W-1:0] data_in,
    output logic              cw_strobe,
    output logic [FLAG_W-1:0] cw_flag,
    output logic [DATA_W-1:0] cw_data,
    output logic [RSEL_W-1:0] read_select,
    output logic              init_done,
    output logic              seq_error
);

    logic               wr_evt;
    logic [STATE_W-1:0] state_q, state_nx;
    logic [RSEL_W-1:0]  ris_sel_q, ris_sel_nx;
    logic               sngl_q, sngl_nx;
    logic               ic4_q, ic4_nx;
    logic               strobe_nx;
    logic               seq_error_nx;
    logic               init_done_nx;
    cw_word_t           word_nx;

    wr_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_edge_sync (
        .clk    (clk),
        .reset  (reset),
        .wr_n   (WR_n),
        .wr_evt (wr_evt)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= UNINIT;
            ris_sel_q <= RSEL_IRR;
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
            cw_strobe <= 1'b0;
            cw_flag   <= FLAG_IDLE;
            cw_data   <= '0;
            init_done <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            state_q   <= state_nx;
            ris_sel_q <= ris_sel_nx;
            sngl_q    <= sngl_nx;
            ic4_q     <= ic4_nx;
            cw_strobe <= strobe_nx;
            cw_flag   <= word_nx.flag;
            cw_data   <= word_nx.data;
            init_done <= init_done_nx;
            seq_error <= seq_error_nx;
        end
    end

    // Next-state and output decode on each accepted write event
    always_comb begin
        state_nx     = state_q;
        ris_sel_nx   = ris_sel_q;
        sngl_nx      = sngl_q;
        ic4_nx       = ic4_q;
        strobe_nx    = 1'b0;
        seq_error_nx = 1'b0;
        init_done_nx = init_done;
        word_nx.flag = FLAG_IDLE;
        word_nx.data = cw_data;

        if (wr_evt && !CS_n) begin
            if (is_icw1(A0, data_in)) begin
                strobe_nx    = 1'b1;
                word_nx.flag = FLAG_ICW1;
                word_nx.data = data_in;
                sngl_nx      = data_in[1];
                ic4_nx       = data_in[0];
                init_done_nx = 1'b0;
                ris_sel_nx   = RSEL_IRR;
                state_nx     = WAIT_ICW2;
            end else begin
                case (state_q)
                    UNINIT: begin
                        seq_error_nx = 1'b1;
                    end
                    WAIT_ICW2: begin
                        if (A0) begin
                            strobe_nx    = 1'b1;
                            word_nx.flag = FLAG_ICW2;
                            word_nx.data = data_in;
                            if (!sngl_q) begin
                                state_nx = WAIT_ICW3;
                            end else if (ic4_q) begin
                                state_nx = WAIT_ICW4;
                            end else begin
                                state_nx     = READY;
                                init_done_nx = 1'b1;
                            end
                        end else begin
                            seq_error_nx = 1'b1;
                        end
                    end
                    WAIT_ICW3: begin
                        if (A0) begin
                            strobe_nx    = 1'b1;
                            word_nx.flag = FLAG_ICW3;
                            word_nx.data = data_in;
                            if (ic4_q) begin
                                state_nx = WAIT_ICW4;
                            end else begin
                                state_nx     = READY;
                                init_done_nx = 1'b1;
                            end
                        end else begin
                            seq_error_nx = 1'b1;
                        end
                    end
                    WAIT_ICW4: begin
                        if (A0) begin
                            strobe_nx    = 1'b1;
                            word_nx.flag = FLAG_ICW4;
                            word_nx.data = data_in;
                            state_nx     = READY;
                            init_done_nx = 1'b1;
                        end else begin
                            seq_error_nx = 1'b1;
                        end
                    end
                    READY: begin
                        strobe_nx    = 1'b1;
                        word_nx.data = data_in;
                        if (A0) begin
                            word_nx.flag = FLAG_OCW1;
                        end else if (!data_in[3]) begin
                            word_nx.flag = FLAG_OCW2;
                        end else begin
                            word_nx.flag = FLAG_OCW3;
                            if (data_in[1]) begin
                                ris_sel_nx = data_in[0] ? RSEL_ISR : RSEL_IRR;
                            end
                        end
                    end
                    default: begin
                        state_nx = UNINIT;
                    end
                endcase
            end
        end
    end

    // Status read select; an active write strobe blocks any read
    always_comb begin
        read_select = RSEL_NONE;
        if (!CS_n && !RD_n && WR_n) begin
            read_select = A0 ? RSEL_IMR : ris_sel_q;
        end
    end

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Scoreboard bench for icw_ocw_sequencer with a queue-based reference model.
module tb_icw_ocw_sequencer;

    localparam int unsigned SYNC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       CS_n, WR_n, RD_n, A0;
    logic [7:0] data_in;
    logic       cw_strobe;
    logic [2:0] cw_flag;
    logic [7:0] cw_data;
    logic [2:0] read_select;
    logic       init_done;
    logic       seq_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        bit         strobe;
        bit         err;
        logic [2:0] flag;
        logic [7:0] data;
        bit         init;
        int         cyc;
    } exp_t;

    exp_t q[$];

    // Reference model: init progress is a list of ICW codes still owed
    int         m_pend[$];
    bit         m_inited;
    bit         m_done;
    logic [2:0] m_ris;

    icw_ocw_sequencer #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .reset       (reset),
        .CS_n        (CS_n),
        .WR_n        (WR_n),
        .RD_n        (RD_n),
        .A0          (A0),
        .data_in     (data_in),
        .cw_strobe   (cw_strobe),
        .cw_flag     (cw_flag),
        .cw_data     (cw_data),
        .read_select (read_select),
        .init_done   (init_done),
        .seq_error   (seq_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_pend.delete();
        m_inited = 1'b0;
        m_done   = 1'b0;
        m_ris    = 3'b001;
    endfunction

    function automatic void model_write(input bit a0, input logic [7:0] d, input bit cs_n, input int ecyc);
        exp_t e;
        e.strobe = 1'b0; e.err = 1'b0; e.flag = 3'd7; e.data = d; e.cyc = ecyc;
        if (cs_n) return;
        if (!a0 && d[4]) begin
            m_pend.delete();
            m_pend.push_back(1);
            if (!d[1]) m_pend.push_back(2);
            if (d[0])  m_pend.push_back(3);
            m_inited = 1'b1;
            m_done   = 1'b0;
            m_ris    = 3'b001;
            e.strobe = 1'b1; e.flag = 3'd0;
        end else if (!m_inited) begin
            e.err = 1'b1;
        end else if (m_pend.size() > 0) begin
            if (a0) begin
                e.strobe = 1'b1;
                e.flag   = 3'(m_pend.pop_front());
                if (m_pend.size() == 0) m_done = 1'b1;
            end else begin
                e.err = 1'b1;
            end
        end else begin
            e.strobe = 1'b1;
            if (a0) e.flag = 3'd4;
            else if (!d[3]) e.flag = 3'd5;
            else begin
                e.flag = 3'd6;
                if (d[1]) m_ris = d[0] ? 3'b101 : 3'b001;
            end
        end
        e.init = m_done;
        q.push_back(e);
    endfunction

    // CPU write cycle; WR_n rises just after edge k, strobe expected after edge k+SYNC+1
    task automatic wr(input bit a0, input logic [7:0] d, input bit cs_n);
        @(posedge clk); #1;
        CS_n = cs_n; A0 = a0; data_in = d; RD_n = 1'b1; WR_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        WR_n = 1'b1;
        model_write(a0, d, cs_n, cyc + int'(SYNC) + 1);
        repeat (SYNC + 3) @(posedge clk);
        #1;
        CS_n = 1'b1; A0 = 1'($urandom); data_in = 8'($urandom);
    endtask

    task automatic rd_check(input bit a0);
        @(posedge clk); #1;
        CS_n = 1'b0; RD_n = 1'b0; A0 = a0;
        #2;
        check(a0 ? "rsel_imr" : "rsel_ris", 32'(read_select), a0 ? 32'h3 : 32'(m_ris));
        RD_n = 1'b1; CS_n = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: pop an expectation whenever the DUT strobes or flags an error
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!cw_strobe) check("flag_idle", 32'(cw_flag), 32'h7);
            if (cw_strobe || seq_error) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {30'd0, cw_strobe, seq_error}, 32'h0);
                end else begin
                    e = q.pop_front();
                    check("strobe", 32'(cw_strobe), 32'(e.strobe));
                    check("seq_error", 32'(seq_error), 32'(e.err));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    check("init_done", 32'(init_done), 32'(e.init));
                    if (e.strobe) begin
                        check("cw_flag", 32'(cw_flag), 32'(e.flag));
                        check("cw_data", 32'(cw_data), 32'(e.data));
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; CS_n = 1'b1; WR_n = 1'b1; RD_n = 1'b1; A0 = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobe", 32'(cw_strobe), 32'h0);
        check("rst_flag", 32'(cw_flag), 32'h7);
        check("rst_data", 32'(cw_data), 32'h0);
        check("rst_init", 32'(init_done), 32'h0);
        check("rst_err", 32'(seq_error), 32'h0);
        CS_n = 1'b0; RD_n = 1'b0; A0 = 1'b0; #1;
        check("rst_rsel", 32'(read_select), 32'h1);
        WR_n = 1'b0; #1;
        check("rsel_wr_prio", 32'(read_select), 32'h0);
        WR_n = 1'b1; RD_n = 1'b1; CS_n = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Single mode without ICW4
        wr(1'b0, 8'h12, 1'b0);
        wr(1'b1, 8'h08, 1'b0);
        check("single_init_done", 32'(init_done), 32'h1);

        // Cascade with ICW4
        wr(1'b0, 8'h11, 1'b0);
        check("icw1_clears_init", 32'(init_done), 32'h0);
        wr(1'b1, 8'h20, 1'b0);
        wr(1'b1, 8'h04, 1'b0);
        wr(1'b1, 8'h01, 1'b0);
        check("cascade_init_done", 32'(init_done), 32'h1);

        // OCW decode and read select
        wr(1'b1, 8'hFE, 1'b0);
        wr(1'b0, 8'h20, 1'b0);
        wr(1'b0, 8'h0B, 1'b0);
        rd_check(1'b0);
        rd_check(1'b1);

        // Out-of-order writes
        do_reset();
        wr(1'b0, 8'h20, 1'b0);
        wr(1'b0, 8'h13, 1'b0);
        wr(1'b0, 8'h20, 1'b0);
        wr(1'b1, 8'h40, 1'b0);
        wr(1'b1, 8'h03, 1'b0);

        // Ignored write while deselected
        wr(1'b1, 8'h55, 1'b1);

        // Restart from WAIT_ICW3
        wr(1'b0, 8'h10, 1'b0);
        wr(1'b1, 8'h20, 1'b0);
        wr(1'b0, 8'h15, 1'b0);
        wr(1'b1, 8'h28, 1'b0);
        wr(1'b1, 8'h02, 1'b0);
        wr(1'b1, 8'h1D, 1'b0);

        // Repeated OCW1
        wr(1'b1, 8'hAA, 1'b0);
        wr(1'b1, 8'hAA, 1'b0);

        // OCW3 back to IRR
        wr(1'b0, 8'h0A, 1'b0);
        rd_check(1'b0);

        // Reset while WR_n low, released with WR_n high
        @(posedge clk); #1;
        CS_n = 1'b0; A0 = 1'b1; data_in = 8'h77; WR_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        WR_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        CS_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("mid_rst_flag", 32'(cw_flag), 32'h7);
        check("mid_rst_init", 32'(init_done), 32'h0);
        rd_check(1'b0);

        // Randomized traffic
        wr(1'b0, 8'h1B, 1'b0);
        for (int i = 0; i < 80; i++) begin
            bit         a0;
            bit         cs;
            logic [7:0] d;
            a0 = 1'($urandom);
            d  = 8'($urandom);
            if (!a0 && $urandom_range(0, 7) != 0) d[4] = 1'b0;
            cs = ($urandom_range(0, 9) == 0);
            wr(a0, d, cs);
            if ($urandom_range(0, 5) == 0) rd_check(1'($urandom));
        end

        repeat (10) @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icw_ocw_sequencer.md
Name: icw_ocw_sequencer

Overview:
- Synchronous write-sequencer in front of the PIC control logic.
- Detects completed CPU write cycles and tracks the ICW1→ICW2→[ICW3]→[ICW4] initialisation order. After initialisation it decodes OCW1/2/3.
- Emits a one-cycle command code and data toward the control logic, plus the read-register select used for status reads.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the WR_n synchroniser (minimum 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- CS_n  in  1  chip select, active low
- WR_n  in  1  CPU write strobe, active low; the write commits on its rising edge
- RD_n  in  1  CPU read strobe, active low
- A0  in  1  address bit
- data_in  in  8  CPU data bus
- cw_strobe  out  1  one-cycle pulse: a command word is valid
- cw_flag  out  3  command code: 0=ICW1, 1=ICW2, 2=ICW3, 3=ICW4, 4=OCW1, 5=OCW2, 6=OCW3, 7=idle
- cw_data  out  8  command word, valid with cw_strobe
- read_select  out  3  011=IMR, 001=IRR, 101=ISR, 000=no read
- init_done  out  1  high once the initialisation sequence is complete
- seq_error  out  1  one-cycle pulse on an out-of-order write

Behaviour:
- Reset values (asynchronous):
  - state=UNINIT, cw_strobe=0, cw_flag=7, cw_data=0, init_done=0, seq_error=0.
  - Internal ris_sel=001 (IRR); SNGL=0, IC4=0.
- Write detection:
  - WR_n passes through SYNC_STAGES flops.
  - A rising edge of the synchronised WR_n asserts internal wr_evt for one cycle.
  - CS_n, A0 and data_in are sampled raw in the wr_evt cycle. The bus must hold them stable from WR_n fall until SYNC_STAGES+1 clocks after WR_n rise.
  - If CS_n=1 at wr_evt, the write is ignored.
- Latency: cw_strobe, cw_flag, cw_data and seq_error are registered and asserted in the clock after wr_evt.
  - For SYNC_STAGES=2, with WR_n rising just after edge k, cw_strobe is high during the cycle following edge k+3.
- cw_flag equals 7 in every cycle where cw_strobe=0. This guarantees a level change even for repeated identical commands.
- ICW1 decode: A0=0 and D4=1 in any state.
  - Emits flag 0.
  - Latches SNGL=D1 and IC4=D0.
  - Clears init_done and resets ris_sel=001.
  - Next state WAIT_ICW2. An ICW1 mid-sequence restarts the sequence.
- WAIT_ICW2, on A0=1: emit flag 1.
  - Next state is WAIT_ICW3 if SNGL=0.
  - Otherwise WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW3, on A0=1: emit flag 2. Next state is WAIT_ICW4 if IC4=1, else READY.
- WAIT_ICW4, on A0=1: emit flag 3. Next state READY.
- init_done is set on the transition into READY.
- Sequence errors:
  - In any WAIT state, A0=0 with D4=0 gives seq_error, no cw_strobe, state unchanged.
  - In UNINIT, any non-ICW1 write gives seq_error, no cw_strobe.
- READY decode:
  - A0=1: OCW1, flag 4.
  - A0=0, D4=0, D3=0: OCW2, flag 5.
  - A0=0, D4=0, D3=1: OCW3, flag 6. If D1=1, set ris_sel to 001 when D0=0, or 101 when D0=1. If D1=0, ris_sel is unchanged. D2 (poll) is passed through in cw_data only.
- read_select (combinational):
  - 000 unless CS_n=0, RD_n=0 and WR_n=1.
  - Otherwise 011 when A0=1, else ris_sel.
  - If WR_n and RD_n are both low, the write has precedence and read_select=000.
- Reset mid-write: the pending event is discarded. The synchroniser is cleared to 1 so no spurious edge is produced after reset release.

Decomposition:
- Package pic_cw_pkg:
  - Flag codes FLAG_ICW1..FLAG_OCW3 and FLAG_IDLE=3'b111.
  - Read-select codes RSEL_IMR, RSEL_IRR, RSEL_ISR, RSEL_NONE.
  - State enum UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- One sub-module: wr_edge_sync, a parameterised synchroniser plus rising-edge detector that outputs wr_evt.

Test Plan:
- Single mode without ICW4:
  - Stimulus: write A0=0 0x12 (D4=1, SNGL=1, IC4=0), then A0=1 0x08.
  - Response: strobes with flag 0 then flag 1, never flag 2/3; init_done=1 after the second strobe.
- Cascade mode with ICW4:
  - Stimulus: writes 0x11, 0x20, 0x04, 0x01.
  - Response: flags 0, 1, 2, 3 in order with matching cw_data; init_done rises after flag 3.
- OCW decode after init:
  - Stimulus: A0=1 0xFE, then A0=0 0x20, then A0=0 0x0B.
  - Response: flags 4, 5, 6. With CS_n=0, RD_n=0, A0=0, read_select=101; with A0=1, read_select=011.
- Out-of-order write:
  - Stimulus: A0=0 0x20 in UNINIT, then again during WAIT_ICW2.
  - Response: seq_error pulses, cw_strobe stays 0, state unchanged.
- Restart and reset:
  - Stimulus: ICW1 issued in WAIT_ICW3. Separately, reset asserted while WR_n is low and then released with WR_n high.
  - Response: ICW1 gives flag 0 and the sequence restarts. The reset case gives no strobe, cw_flag=7 and read_select source 001.
- Repeated OCW1:
  - Stimulus: 0xAA written twice back-to-back.
  - Response: two separate strobes; cw_flag returns to 7 between them.
